// File: rtl/seg_display_scheduler_pkg.sv
// Shared types, digit codes and the 7-segment glyph decode for the display scheduler.
package seg_display_scheduler_pkg;

    localparam int unsigned BIN_W = 32;
    localparam int unsigned BCD_W = 16;

    typedef enum logic [1:0] {
        PAGE_OUT = 2'd0,
        PAGE_PC  = 2'd1,
        PAGE_FP  = 2'd2
    } page_t;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_LOAD  = 2'd1,
        CONV_SHIFT = 2'd2,
        CONV_DONE  = 2'd3
    } conv_state_t;

    localparam logic [3:0] DIG_DASH  = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } digits_t;

    localparam digits_t DIGITS_RESET = digits_t'({4'd4, 4'd3, 4'd2, 4'd1});
    localparam digits_t DIGITS_DASH  = digits_t'({4{DIG_DASH}});

    // Active-low {g,f,e,d,c,b,a} glyphs
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:      seg_decode = 7'h40;
            4'd1:      seg_decode = 7'h79;
            4'd2:      seg_decode = 7'h24;
            4'd3:      seg_decode = 7'h30;
            4'd4:      seg_decode = 7'h19;
            4'd5:      seg_decode = 7'h12;
            4'd6:      seg_decode = 7'h02;
            4'd7:      seg_decode = 7'h78;
            4'd8:      seg_decode = 7'h00;
            4'd9:      seg_decode = 7'h10;
            DIG_DASH:  seg_decode = 7'h3F;
            DIG_BLANK: seg_decode = 7'h7F;
            default:   seg_decode = 7'h7F;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scheduler_bin2bcd.sv
// Sequential 32-bit to 4-digit double-dabble; result is value mod 10000.
module bin2bcd_seq
    import seg_display_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned CNT_W = $clog2(BIN_W);

    conv_state_t      state;
    conv_state_t      state_next;
    logic [BIN_W-1:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-2:0] adj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort restarts from LOAD regardless of the current state
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = CONV_LOAD;
        end else begin
            case (state)
                CONV_IDLE:  if (start) state_next = CONV_LOAD;
                CONV_LOAD:  state_next = CONV_SHIFT;
                CONV_SHIFT: if (cnt == CNT_W'(BIN_W - 1)) state_next = CONV_DONE;
                CONV_DONE:  state_next = CONV_IDLE;
                default:    state_next = CONV_IDLE;
            endcase
        end
    end

    // Add-3 correction; the top digit's carry-out is dropped by the shift
    always_comb begin
        adj = bcd[BCD_W-2:0];
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        adj[14:12] = 3'((bcd[15:12] >= 4'd5) ? bcd[15:12] + 4'd3 : bcd[15:12]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            busy <= (state_next != CONV_IDLE);
            done <= (state_next == CONV_DONE);
            case (state)
                CONV_LOAD: begin
                    shreg <= bin;
                    bcd   <= '0;
                    cnt   <= '0;
                end
                CONV_SHIFT: begin
                    bcd   <= {adj, shreg[BIN_W-1]};
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Multiplexed 4-digit 7-segment display shared between OUT, PC and FP pages.
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 208333,
    parameter int unsigned PAGE_FRAMES = 240
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        out_valid,
    input  logic [31:0] out_value,
    input  logic [9:0]  pc,
    input  logic [31:0] fp,
    input  logic        halt,
    output logic [7:0]  seg,
    output logic [3:0]  dig,
    output logic [1:0]  page,
    output logic        conv_busy
);

    localparam int unsigned DIV_W   = $clog2(SCAN_DIV);
    localparam int unsigned DWELL_W = $clog2(PAGE_FRAMES + 1);

    logic [DIV_W-1:0]   presc;
    logic               tick;
    logic [1:0]         digit_sel;
    logic               frame;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_next;
    page_t              page_q;
    page_t              page_next;
    logic [31:0]        out_reg;
    digits_t            digits;
    logic [3:0]         cur_code;
    logic               dp_on;
    logic [BIN_W-1:0]   conv_bin;
    logic [BCD_W-1:0]   conv_bcd;
    logic               conv_done;

    assign tick  = (presc == DIV_W'(SCAN_DIV - 1));
    assign frame = tick && (digit_sel == 2'd3);
    assign page  = page_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q <= PAGE_OUT;
            dwell  <= '0;
        end else begin
            page_q <= page_next;
            dwell  <= dwell_next;
        end
    end

    // out_valid pins the OUT page and restarts its dwell
    always_comb begin
        page_next  = page_q;
        dwell_next = dwell;
        if (out_valid) begin
            page_next  = PAGE_OUT;
            dwell_next = '0;
        end else if (frame) begin
            if (dwell == DWELL_W'(PAGE_FRAMES - 1)) begin
                dwell_next = '0;
                case (page_q)
                    PAGE_OUT: page_next = PAGE_PC;
                    PAGE_PC:  page_next = PAGE_FP;
                    default:  page_next = PAGE_OUT;
                endcase
            end else begin
                dwell_next = dwell + DWELL_W'(1);
            end
        end
    end

    always_comb begin
        case (page_q)
            PAGE_PC: conv_bin = BIN_W'(pc);
            PAGE_FP: conv_bin = fp;
            default: conv_bin = out_reg;
        endcase
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (frame && !conv_busy),
        .abort (out_valid),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg <= '0;
            digits  <= DIGITS_RESET;
        end else begin
            if (out_valid) begin
                out_reg <= out_value;
            end
            // A completed result superseded by a new out_valid is discarded
            if (conv_done && !out_valid) begin
                digits <= (halt && page_q == PAGE_PC) ? DIGITS_DASH : digits_t'(conv_bcd);
            end
        end
    end

    always_comb begin
        case (digit_sel)
            2'd1:    cur_code = digits.d1;
            2'd2:    cur_code = digits.d2;
            2'd3:    cur_code = digits.d3;
            default: cur_code = digits.d0;
        endcase
        dp_on = (digit_sel == (2'd3 - 2'(page_q)));
    end

    // Digit slot outputs are latched on the tick, then the slot index advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc     <= '0;
            digit_sel <= '0;
            dig       <= 4'b1111;
            seg       <= 8'hFF;
        end else begin
            presc <= tick ? '0 : presc + DIV_W'(1);
            if (tick) begin
                dig       <= ~(4'b0001 << digit_sel);
                seg       <= {~dp_on, seg_decode(cur_code)};
                digit_sel <= digit_sel + 2'd1;
            end
        end
    end

endmodule
